output_accum_ram: RTL and testbench

Parametrised output buffer for the convolution datapath's results stage. It stores DEPTH result words and accepts plain overwrites or signed read-modify-write accumulation of partial sums. It adds a registered read port, per-entry valid tracking, a single-cycle clear, and sticky saturation status. It sits after the MAC array and is drained by the output sequencer.

---
 rtl/nn_pkg.sv | 20 ++
 rtl/output_accum_ram_sat_add.sv | 38 +++
 rtl/output_accum_ram.sv | 133 +++++++++++++
 tb/tb_output_accum_ram.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the convolution datapath: op mode encoding,
// default word width and signed saturation limits.
package nn_pkg;

  localparam int NN_DATA_WIDTH = 16;

  typedef enum logic {
    MODE_OVERWRITE = 1'b0,
    MODE_ACCUM     = 1'b1
  } mode_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/output_accum_ram_sat_add.sv
// Combinational signed adder for partial-sum accumulation.
// OUTPUT_ACCUM_RAM_SAT_EN selects clamping; otherwise the sum wraps.
module sat_add
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = NN_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] sum_o,
  output logic                         clamp_o
);

  logic signed [DATA_WIDTH:0] sum_full;
  logic                       ovf;

  assign sum_full = {a_i[DATA_WIDTH-1], a_i} + {b_i[DATA_WIDTH-1], b_i};
  // Overflow when the extra sign bit disagrees with the result sign bit.
  assign ovf      = sum_full[DATA_WIDTH] ^ sum_full[DATA_WIDTH-1];

`ifdef OUTPUT_ACCUM_RAM_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] MIN_V = DATA_WIDTH'(sat_min(DATA_WIDTH));

  always_comb begin
    sum_o   = sum_full[DATA_WIDTH-1:0];
    clamp_o = 1'b0;
    if (ovf) begin
      sum_o   = sum_full[DATA_WIDTH] ? MIN_V : MAX_V;
      clamp_o = 1'b1;
    end
  end
`else
  assign sum_o   = sum_full[DATA_WIDTH-1:0];
  assign clamp_o = 1'b0 & ovf;
`endif

endmodule

// File: rtl/output_accum_ram.sv
// Result buffer with overwrite / signed accumulate, registered read port,
// valid tracking, single-cycle clear and sticky saturation status.
module output_accum_ram
  import nn_pkg::*;
#(
  parameter  int DATA_WIDTH = NN_DATA_WIDTH,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic signed [DATA_WIDTH-1:0] write_data,
  input  logic                         enable,
  input  logic                         write,
  input  logic                         accumulate,
  input  logic                         clear,
  input  logic                         read_enable,
  input  logic [ADDR_WIDTH-1:0]        read_address,
  output logic signed [DATA_WIDTH-1:0] read_data,
  output logic                         read_valid,
  output logic                         read_hit,
  output logic [ADDR_WIDTH:0]          valid_count,
  output logic                         sat_flag
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [ADDR_WIDTH:0]          cnt_q, cnt_d;
  logic                         sat_q, sat_d;

  logic                         p_vld_q;
  logic [ADDR_WIDTH-1:0]        p_addr_q;
  logic signed [DATA_WIDTH-1:0] p_data_q;
  mode_e                        p_mode_q;

  logic                         accept, commit, is_acc, acc_clamp;
  logic signed [DATA_WIDTH-1:0] old_val, acc_sum, result;

  logic                         rd_in_range, rd_fwd, rd_hit_d;
  logic signed [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                         rd_valid_q, rd_hit_q;

  // Stage 0: accept op into pending stage P; out-of-range targets are dropped here.
  assign accept = enable && write && ({1'b0, address} < DEPTH_L);

  always_ff @(posedge clock) begin
    if (reset) p_vld_q <= 1'b0;
    else       p_vld_q <= accept;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      p_addr_q <= address;
      p_data_q <= write_data;
      p_mode_q <= accumulate ? MODE_ACCUM : MODE_OVERWRITE;
    end
  end

  // Stage 1: read-modify-write of P against committed memory.
  assign commit  = p_vld_q && !clear && !reset;
  assign is_acc  = (p_mode_q == MODE_ACCUM);
  assign old_val = valid_q[p_addr_q] ? mem_q[p_addr_q] : '0;

  sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
    .a_i     (old_val),
    .b_i     (p_data_q),
    .sum_o   (acc_sum),
    .clamp_o (acc_clamp)
  );

  assign result = is_acc ? acc_sum : p_data_q;

  always_ff @(posedge clock) begin
    if (commit) mem_q[p_addr_q] <= result;
  end

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      valid_d = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (commit) begin
      valid_d[p_addr_q] = 1'b1;
      if (!valid_q[p_addr_q] && cnt_q != DEPTH_L) cnt_d = cnt_q + 1'b1;
      if (is_acc && acc_clamp) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Read port: the op in P is forwarded so the read reflects all earlier ops.
  assign rd_in_range = ({1'b0, read_address} < DEPTH_L);
  assign rd_fwd      = p_vld_q && (p_addr_q == read_address);
  assign rd_hit_d    = rd_in_range && (rd_fwd || valid_q[read_address]);
  assign rd_data_d   = !rd_hit_d ? '0 : (rd_fwd ? result : mem_q[read_address]);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= read_enable;
      if (read_enable) begin
        rd_hit_q  <= rd_hit_d;
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign read_data   = rd_data_q;
  assign read_valid  = rd_valid_q;
  assign read_hit    = rd_hit_q;
  assign valid_count = cnt_q;
  assign sat_flag    = sat_q;

endmodule

// File: tb/tb_output_accum_ram.sv
// Scoreboard bench for output_accum_ram: reads push expectations, a negedge
// monitor pops and compares whenever read_valid is presented.
module tb_output_accum_ram;

  localparam int DW = 16;
  localparam int AW = 3;

`ifdef OUTPUT_ACCUM_RAM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [AW-1:0]        address = '0;
  logic signed [DW-1:0] write_data = '0;
  logic                 enable = 1'b0, write = 1'b0, accumulate = 1'b0, clear = 1'b0;
  logic                 read_enable = 1'b0;
  logic [AW-1:0]        read_address = '0;
  logic signed [DW-1:0] read_data;
  logic                 read_valid, read_hit;
  logic [AW:0]          valid_count;
  logic                 sat_flag;

  output_accum_ram #(.DATA_WIDTH(DW), .DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .enable       (enable),
    .write        (write),
    .accumulate   (accumulate),
    .clear        (clear),
    .read_enable  (read_enable),
    .read_address (read_address),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .read_hit     (read_hit),
    .valid_count  (valid_count),
    .sat_flag     (sat_flag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        hit;
    logic [15:0] data;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   rid = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (read_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=read_valid required=no_read");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("read%0d_hit", e.id), {31'd0, read_hit}, {31'd0, e.hit});
        chk($sformatf("read%0d_data", e.id), {16'd0, $unsigned(read_data)}, {16'd0, e.data});
      end
    end
  end

  task automatic cyc(input bit op, input bit acc, input int a, input int d,
                     input bit rd, input int ra, input bit eh, input int ed, input bit clr);
    enable       = op;
    write        = op;
    accumulate   = acc;
    address      = AW'(a);
    write_data   = DW'(d);
    read_enable  = rd;
    read_address = AW'(ra);
    clear        = clr;
    if (rd) begin
      rid++;
      q.push_back('{eh, 16'(ed), rid});
    end
    @(posedge clock);
    #1;
    enable      = 1'b0;
    write       = 1'b0;
    accumulate  = 1'b0;
    read_enable = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic op(input int a, input int d, input bit acc);
    cyc(1'b1, acc, a, d, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int ra, input bit eh, input int ed);
    cyc(1'b0, 1'b0, 0, 0, 1'b1, ra, eh, ed, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_read_valid"}, {31'd0, read_valid}, 32'd0);
    chk({tag, "_read_hit"}, {31'd0, read_hit}, 32'd0);
    chk({tag, "_read_data"}, {16'd0, $unsigned(read_data)}, 32'd0);
    chk({tag, "_valid_count"}, {28'd0, valid_count}, 32'd0);
    chk({tag, "_sat_flag"}, {31'd0, sat_flag}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_outputs_zero("reset");

    rd(3, 1'b0, 0);

    // Overwrite then two chained accumulates; the read forwards the last one from P.
    op(2, 'h0010, 1'b0);
    op(2, 'h0005, 1'b1);
    op(2, 'h0005, 1'b1);
    rd(2, 1'b1, 'h001A);
    chk("count_after_addr2", {28'd0, valid_count}, 32'd1);
    rd(2, 1'b1, 'h001A);

    // Accumulate into an invalid entry, read forwarded next cycle.
    op(5, 'h0007, 1'b1);
    rd(5, 1'b1, 'h0007);
    chk("count_after_addr5", {28'd0, valid_count}, 32'd2);

    // Same-cycle read does not see the op; the following read does.
    cyc(1'b1, 1'b1, 2, 'h0001, 1'b1, 2, 1'b1, 'h001A, 1'b0);
    rd(2, 1'b1, 'h001B);

    // Positive overflow.
    op(1, 'h7FF0, 1'b0);
    op(1, 'h0020, 1'b1);
    idle();
    rd(1, 1'b1, SAT ? 'h7FFF : 'h8010);
    chk("sat_flag_pos", {31'd0, sat_flag}, {31'd0, SAT});
    chk("count_after_addr1", {28'd0, valid_count}, 32'd3);

    // Negative overflow: 0x8000 + (-1).
    op(0, 'h8000, 1'b0);
    op(0, 'hFFFF, 1'b1);
    idle();
    rd(0, 1'b1, SAT ? 'h8000 : 'h7FFF);
    chk("count_after_addr0", {28'd0, valid_count}, 32'd4);

    // Fill every entry; count saturates at DEPTH.
    for (int i = 0; i < 8; i++) op(i, 'h0100 + i, 1'b0);
    idle();
    chk("count_full", {28'd0, valid_count}, 32'd8);

    // Clear discards the op pending in P (addr 3), keeps the op accepted with it,
    // and the read issued alongside returns the pre-clear forwarded value.
    op(3, 'h0055, 1'b0);
    cyc(1'b1, 1'b0, 4, 'h00AA, 1'b1, 3, 1'b1, 'h0055, 1'b1);
    chk("count_at_clear", {28'd0, valid_count}, 32'd0);
    chk("sat_after_clear", {31'd0, sat_flag}, 32'd0);
    idle();
    chk("count_after_clear", {28'd0, valid_count}, 32'd1);
    for (int i = 0; i < 8; i++) rd(i, (i == 4), (i == 4) ? 'h00AA : 0);

    // Reset with an accumulate pending to addr 6.
    cyc(1'b1, 1'b1, 6, 'h0009, 1'b1, 4, 1'b1, 'h00AA, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk_outputs_zero("post_reset");
    rd(6, 1'b0, 0);
    rd(4, 1'b0, 0);

    repeat (3) idle();
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
